// File: rtl/jt053246_draw.sv
// Sprite row drawer: fetches two 4bpp ROM words per tile row and writes opaque pixels to the line buffer.
// Define JT053246_DRAW_ZOOM_EN to enable horizontal zoom (hzoom/hz_keep); otherwise every tile is 16 pixels.
module jt053246_draw (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dr_start,
    output logic        dr_busy,
    input  logic [15:0] code,
    input  logic [9:0]  attr,
    input  logic [8:0]  hpos,
    input  logic        hflip,
    input  logic        vflip,
    input  logic [3:0]  ysub,
    input  logic [9:0]  hzoom,
    input  logic        hz_keep,
    output logic [22:2] rom_addr,
    output logic        rom_cs,
    input  logic [31:0] rom_data,
    input  logic        rom_ok,
    output logic [8:0]  buf_addr,
    output logic [13:0] buf_din,
    output logic        buf_we
);

    typedef enum logic [1:0] {IDLE, FETCH0, FETCH1, DRAW} state_t;

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic        rom_cs_q, rom_cs_d;
    logic        arm_q, arm_d;
    logic        hflip_q, hflip_d;
    logic        buf_we_q, buf_we_d;
    logic [20:0] rom_addr_q, rom_addr_d;
    logic [31:0] word0_q, word0_d;
    logic [31:0] word1_q, word1_d;
    logic [9:0]  attr_q, attr_d;
    logic [8:0]  x_q, x_d;
    logic [8:0]  buf_addr_q, buf_addr_d;
    logic [13:0] buf_din_q, buf_din_d;

    logic [3:0]  cur_idx, nxt_idx, pix_idx, pix_sel, pix;
    logic [63:0] pix_row;
    logic        last_pix;

`ifdef JT053246_DRAW_ZOOM_EN
    logic [10:0] src_q, src_d, src_nxt;
    logic [9:0]  hzeff_q, hzeff_d;

    assign src_nxt  = src_q + {1'b0, hzeff_q};
    assign cur_idx  = src_q[9:6];
    assign nxt_idx  = src_nxt[9:6];
    assign last_pix = src_nxt[10];
`else
    logic [3:0]  cnt_q, cnt_d;
    logic        unused_zoom;

    assign unused_zoom = ^{hzoom, hz_keep};
    assign cur_idx  = cnt_q;
    assign nxt_idx  = cnt_q + 4'd1;
    assign last_pix = &cnt_q;
`endif

    // The first pixel is emitted on the word-1 capture edge, straight from rom_data.
    assign pix_row = (state_q == DRAW) ? {word0_q, word1_q} : {word0_q, rom_data};
    assign pix_idx = (state_q == DRAW) ? nxt_idx : cur_idx;
    // Pixel i sits at bit 4*(15-i); for a 4-bit index 15-i is simply ~i.
    assign pix_sel = hflip_q ? pix_idx : ~pix_idx;
    assign pix     = pix_row[{pix_sel, 2'b00} +: 4];

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        rom_cs_d   = rom_cs_q;
        arm_d      = arm_q;
        hflip_d    = hflip_q;
        buf_we_d   = 1'b0;
        rom_addr_d = rom_addr_q;
        word0_d    = word0_q;
        word1_d    = word1_q;
        attr_d     = attr_q;
        x_d        = x_q;
        buf_addr_d = buf_addr_q;
        buf_din_d  = buf_din_q;
`ifdef JT053246_DRAW_ZOOM_EN
        src_d      = src_q;
        hzeff_d    = hzeff_q;
`else
        cnt_d      = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (dr_start) begin
                    state_d    = FETCH0;
                    busy_d     = 1'b1;
                    rom_cs_d   = 1'b1;
                    arm_d      = 1'b0;
                    rom_addr_d = {code, ysub ^ {4{vflip}}, 1'b0};
                    attr_d     = attr;
                    hflip_d    = hflip;
`ifdef JT053246_DRAW_ZOOM_EN
                    hzeff_d    = (hzoom < 10'h010) ? 10'h010 : hzoom;
                    src_d      = hz_keep ? src_q - 11'h400 : '0;
                    x_d        = hz_keep ? x_q : hpos;
`else
                    cnt_d      = '0;
                    x_d        = hpos;
`endif
                end
            end
            FETCH0: begin
                arm_d = 1'b1;
                if (arm_q && rom_ok) begin
                    word0_d       = rom_data;
                    rom_addr_d[0] = 1'b1;
                    arm_d         = 1'b0;
                    state_d       = FETCH1;
                end
            end
            FETCH1: begin
                arm_d = 1'b1;
                if (arm_q && rom_ok) begin
                    word1_d    = rom_data;
                    rom_cs_d   = 1'b0;
                    arm_d      = 1'b0;
                    state_d    = DRAW;
                    buf_we_d   = |pix;
                    buf_addr_d = x_q;
                    buf_din_d  = {attr_q, pix};
                end
            end
            DRAW: begin
                x_d = x_q + 9'd1;
`ifdef JT053246_DRAW_ZOOM_EN
                src_d = src_nxt;
`else
                cnt_d = nxt_idx;
`endif
                if (last_pix) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    buf_we_d   = |pix;
                    buf_addr_d = x_q + 9'd1;
                    buf_din_d  = {attr_q, pix};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            rom_cs_q   <= 1'b0;
            arm_q      <= 1'b0;
            hflip_q    <= 1'b0;
            buf_we_q   <= 1'b0;
            rom_addr_q <= '0;
            word0_q    <= '0;
            word1_q    <= '0;
            attr_q     <= '0;
            x_q        <= '0;
            buf_addr_q <= '0;
            buf_din_q  <= '0;
`ifdef JT053246_DRAW_ZOOM_EN
            src_q      <= '0;
            hzeff_q    <= '0;
`else
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            rom_cs_q   <= rom_cs_d;
            arm_q      <= arm_d;
            hflip_q    <= hflip_d;
            buf_we_q   <= buf_we_d;
            rom_addr_q <= rom_addr_d;
            word0_q    <= word0_d;
            word1_q    <= word1_d;
            attr_q     <= attr_d;
            x_q        <= x_d;
            buf_addr_q <= buf_addr_d;
            buf_din_q  <= buf_din_d;
`ifdef JT053246_DRAW_ZOOM_EN
            src_q      <= src_d;
            hzeff_q    <= hzeff_d;
`else
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign dr_busy  = busy_q;
    assign rom_cs   = rom_cs_q;
    assign rom_addr = rom_addr_q;
    assign buf_we   = buf_we_q;
    assign buf_addr = buf_addr_q;
    assign buf_din  = buf_din_q;

endmodule

// File: tb/tb_jt053246_draw.sv
// Directed bench for jt053246_draw: a pixel-list model predicts every line-buffer write and ROM address.
// Follows JT053246_DRAW_ZOOM_EN so the same bench covers both builds.
module tb_jt053246_draw;

`ifdef JT053246_DRAW_ZOOM_EN
    localparam bit ZOOM = 1'b1;
`else
    localparam bit ZOOM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dr_start = 1'b0;
    logic        dr_busy;
    logic [15:0] code = '0;
    logic [9:0]  attr = '0;
    logic [8:0]  hpos = '0;
    logic        hflip = 1'b0;
    logic        vflip = 1'b0;
    logic [3:0]  ysub = '0;
    logic [9:0]  hzoom = 10'h040;
    logic        hz_keep = 1'b0;
    logic [22:2] rom_addr;
    logic        rom_cs;
    logic [31:0] rom_data = '0;
    logic        rom_ok = 1'b0;
    logic [8:0]  buf_addr;
    logic [13:0] buf_din;
    logic        buf_we;

    jt053246_draw dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .dr_start (dr_start),
        .dr_busy  (dr_busy),
        .code     (code),
        .attr     (attr),
        .hpos     (hpos),
        .hflip    (hflip),
        .vflip    (vflip),
        .ysub     (ysub),
        .hzoom    (hzoom),
        .hz_keep  (hz_keep),
        .rom_addr (rom_addr),
        .rom_cs   (rom_cs),
        .rom_data (rom_data),
        .rom_ok   (rom_ok),
        .buf_addr (buf_addr),
        .buf_din  (buf_din),
        .buf_we   (buf_we)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ROM responder: rom_ok arrives lat cycles after the address changes; with garbage set,
    // rom_ok is also high earlier but carries junk data that must not be captured.
    logic [31:0] tw0 = '0, tw1 = '0;
    int          lat = 1;
    bit          garbage = 1'b0;
    logic        prev_cs = 1'b0;
    logic [20:0] prev_addr = '0;
    int          age = 0;

    initial forever begin
        @(negedge clk);
        if (rom_cs && (!prev_cs || rom_addr != prev_addr)) age = 0;
        else if (age < 1000) age++;
        prev_cs   = rom_cs;
        prev_addr = rom_addr;
        rom_ok    = rom_cs && (garbage || age >= lat);
        rom_data  = (rom_cs && age >= lat) ? (rom_addr[2] ? tw1 : tw0) : 32'hA5C3_3C5A;
    end

    // Model state and expected write list
    logic [8:0]  qa[$];
    logic [13:0] qd[$];
    int          m_src = 0;
    int          m_x = 0;
    logic [19:0] exp_prefix = '0;
    bit          chk_en = 1'b0;
    int          cs_cnt = 0;
    int          wr_cnt = 0;
    logic [20:0] first_ra, last_ra;
    logic [8:0]  first_wa, last_wa;
    logic [3:0]  first_px, last_px;

    function automatic logic [3:0] nib(input logic [31:0] w0, input logic [31:0] w1, input int idx);
        logic [31:0] w;
        w = (idx < 8) ? w0 : w1;
        w = w >> (28 - 4 * (idx % 8));
        return w[3:0];
    endfunction

    task automatic model_tile(input logic [9:0] a, input logic [8:0] hp, input logic hf,
                              input logic [9:0] hz, input logic keep,
                              input logic [31:0] w0, input logic [31:0] w1, output int npix);
        int src, x, step, idx;
        logic [3:0] p;
        logic [8:0] xa;
        step = ZOOM ? ((hz < 10'h010) ? 16 : int'(hz)) : 64;
        src  = (ZOOM && keep) ? m_src - 1024 : 0;
        x    = (ZOOM && keep) ? m_x : int'(hp);
        npix = 0;
        do begin
            idx = src / 64;
            if (hf) idx = 15 - idx;
            p = nib(w0, w1, idx);
            if (p != 4'd0) begin
                xa = x[8:0];
                qa.push_back(xa);
                qd.push_back({a, p});
            end
            npix++;
            src += step;
            x = (x + 1) % 512;
        end while (src < 1024);
        m_src = src;
        m_x   = x;
    endtask

    // Compare process: every ROM request and every line-buffer write
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            if (rom_cs === 1'b1) begin
                chk("rom_addr", rom_addr, {exp_prefix, (cs_cnt >= lat + 1) ? 1'b1 : 1'b0});
                if (cs_cnt == 0) first_ra = rom_addr;
                last_ra = rom_addr;
                cs_cnt++;
            end
            if (buf_we === 1'b1) begin
                if (qa.size() == 0) begin
                    chk("extra_buf_we", 1, 0);
                end else begin
                    chk("buf_addr", buf_addr, qa.pop_front());
                    chk("buf_din", buf_din, qd.pop_front());
                end
                if (wr_cnt == 0) begin
                    first_wa = buf_addr;
                    first_px = buf_din[3:0];
                end
                last_wa = buf_addr;
                last_px = buf_din[3:0];
                wr_cnt++;
            end
        end
    end

    task automatic launch(input logic [15:0] c, input logic [9:0] a, input logic [8:0] hp,
                          input logic hf, input logic vf, input logic [3:0] ys,
                          input logic [9:0] hz, input logic keep,
                          input logic [31:0] w0, input logic [31:0] w1,
                          input int l, input bit g, output int npix);
        @(negedge clk);
        tw0 = w0; tw1 = w1; lat = l; garbage = g;
        exp_prefix = {c, ys ^ {4{vf}}};
        cs_cnt = 0;
        wr_cnt = 0;
        model_tile(a, hp, hf, hz, keep, w0, w1, npix);
        code = c; attr = a; hpos = hp; hflip = hf; vflip = vf; ysub = ys;
        hzoom = hz; hz_keep = keep;
        dr_start = 1'b1;
        @(negedge clk);
        dr_start = 1'b0;
    endtask

    task automatic run_tile(input logic [15:0] c, input logic [9:0] a, input logic [8:0] hp,
                            input logic hf, input logic vf, input logic [3:0] ys,
                            input logic [9:0] hz, input logic keep,
                            input logic [31:0] w0, input logic [31:0] w1,
                            input int l, input bit g, input bit restart, output int cycles);
        int npix;
        launch(c, a, hp, hf, vf, ys, hz, keep, w0, w1, l, g, npix);
        cycles = 0;
        while (dr_busy === 1'b1 && cycles < 400) begin
            cycles++;
            if (restart && cycles == 3) begin
                code = ~c; attr = ~a; hpos = hp + 9'd77; hflip = ~hf; vflip = ~vf;
                ysub = ~ys; hzoom = 10'h011; hz_keep = ~keep;
            end
            dr_start = restart && (cycles == 3 || cycles == 12);
            @(negedge clk);
        end
        dr_start = 1'b0;
        chk("busy_cycles", cycles, 2 * (l + 1) + npix);
        @(negedge clk);
        @(negedge clk);
        chk("writes_missing", qa.size(), 0);
        chk("rom_cycles", cs_cnt, 2 * (l + 1));
        qa.delete();
        qd.delete();
    endtask

    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        int cyc;
        int npix;

        #2;
        chk("rst_busy", dr_busy, 0);
        chk("rst_rom_cs", rom_cs, 0);
        chk("rst_buf_we", buf_we, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_buf_addr", buf_addr, 0);
        chk("rst_buf_din", buf_din, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Basic tile: 16 opaque pixels, one-cycle ROM latency
        run_tile(16'h0012, 10'h155, 9'h020, 1'b0, 1'b0, 4'd3, 10'h040, 1'b0,
                 32'h12345678, 32'h9ABCDEF1, 1, 1'b0, 1'b0, cyc);
        chk("t1_busy", cyc, 20);
        chk("t1_writes", wr_cnt, 16);
        chk("t1_first_wa", first_wa, 9'h020);
        chk("t1_last_wa", last_wa, 9'h02F);
        chk("t1_first_ra", first_ra, {16'h0012, 4'h3, 1'b0});
        chk("t1_last_ra", last_ra, {16'h0012, 4'h3, 1'b1});
        chk("t1_last_px", last_px, 4'h1);

        // vflip, transparent pixels, early junk rom_ok, ignored restarts while busy
        run_tile(16'hBEEF, 10'h2AA, 9'h100, 1'b0, 1'b1, 4'd5, 10'h040, 1'b0,
                 32'h0F00A0B0, 32'h000000C7, 1, 1'b1, 1'b1, cyc);
        chk("t2_writes", wr_cnt, 5);
        chk("t2_first_wa", first_wa, 9'h101);
        chk("t2_last_wa", last_wa, 9'h10F);
        chk("t2_first_ra", first_ra, {16'hBEEF, 4'hA, 1'b0});

        // hflip, slower ROM
        run_tile(16'h0345, 10'h001, 9'h040, 1'b1, 1'b0, 4'd0, 10'h040, 1'b0,
                 32'h12345678, 32'h9ABCDEF0, 3, 1'b0, 1'b0, cyc);
        chk("t3_busy", cyc, 24);
        chk("t3_writes", wr_cnt, 15);
        chk("t3_first_px", first_px, 4'hF);
        chk("t3_last_px", last_px, 4'h1);
        chk("t3_first_wa", first_wa, 9'h041);

        // x wrap at 9 bits
        run_tile(16'h0777, 10'h3FF, 9'h1FC, 1'b0, 1'b0, 4'd9, 10'h040, 1'b0,
                 32'h12345678, 32'h9ABCDEF1, 1, 1'b0, 1'b0, cyc);
        chk("t4_first_wa", first_wa, 9'h1FC);
        chk("t4_last_wa", last_wa, 9'h00B);

        // Half size, double size, clamped enlargement
        run_tile(16'h0100, 10'h0F0, 9'h010, 1'b0, 1'b0, 4'd1, 10'h080, 1'b0,
                 32'h12345678, 32'h9ABCDEF1, 1, 1'b0, 1'b0, cyc);
        chk("t5_writes", wr_cnt, ZOOM ? 8 : 16);
        chk("t5_busy", cyc, ZOOM ? 12 : 20);
        chk("t5_last_px", last_px, ZOOM ? 4'hF : 4'h1);

        run_tile(16'h0101, 10'h00F, 9'h050, 1'b0, 1'b0, 4'd2, 10'h020, 1'b0,
                 32'h12345678, 32'h9ABCDEF1, 1, 1'b0, 1'b0, cyc);
        chk("t6_writes", wr_cnt, ZOOM ? 32 : 16);

        run_tile(16'h0102, 10'h123, 9'h060, 1'b1, 1'b0, 4'd4, 10'h004, 1'b0,
                 32'h12345678, 32'h9ABCDEF1, 1, 1'b0, 1'b0, cyc);
        chk("t7_writes", wr_cnt, ZOOM ? 64 : 16);
        chk("t7_busy", cyc, ZOOM ? 68 : 20);

        // Non-power-of-two zoom, then a continuation tile
        run_tile(16'h0200, 10'h0AB, 9'h080, 1'b0, 1'b0, 4'd6, 10'h030, 1'b0,
                 32'h12345678, 32'h9ABCDEF1, 1, 1'b0, 1'b0, cyc);
        chk("t8_writes", wr_cnt, ZOOM ? 22 : 16);
        run_tile(16'h0201, 10'h0AB, 9'h1A0, 1'b0, 1'b0, 4'd6, 10'h030, 1'b1,
                 32'h12345678, 32'h9ABCDEF1, 1, 1'b0, 1'b0, cyc);
        chk("t9_writes", wr_cnt, ZOOM ? 21 : 16);
        chk("t9_first_wa", first_wa, ZOOM ? 9'h096 : 9'h1A0);

        // Reset in the middle of DRAW
        launch(16'h0300, 10'h0CC, 9'h0C0, 1'b0, 1'b0, 4'd7, 10'h040, 1'b0,
               32'h12345678, 32'h9ABCDEF1, 1, 1'b0, npix);
        cyc = 0;
        while (wr_cnt < 3 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        chk("rst_wait_writes", wr_cnt >= 3, 1);
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", dr_busy, 0);
        chk("mid_rst_buf_we", buf_we, 0);
        chk("mid_rst_rom_cs", rom_cs, 0);
        chk("mid_rst_rom_addr", rom_addr, 0);
        chk("mid_rst_buf_addr", buf_addr, 0);
        chk("mid_rst_buf_din", buf_din, 0);
        qa.delete();
        qd.delete();
        m_src = 0;
        m_x = 0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_buf_we", buf_we, 0);
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_buf_we", buf_we, 0);
            chk("post_rst_busy", dr_busy, 0);
        end
        chk_en = 1'b1;

        run_tile(16'h0400, 10'h1E1, 9'h033, 1'b0, 1'b0, 4'd8, 10'h040, 1'b0,
                 32'h12345678, 32'h9ABCDEF1, 1, 1'b0, 1'b0, cyc);
        chk("t11_busy", cyc, 20);
        chk("t11_writes", wr_cnt, 16);
        chk("t11_first_wa", first_wa, 9'h033);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
